// File: rtl/adpll_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adpll_pkg
//  Brief    : Shared state encoding and saturating magnitude helper for the
//             ADPLL lock detector.
//  Revision : 1.0 - initial release
// ============================================================================
package adpll_pkg;

    // Detector state encoding, exported directly on state_o.
    localparam int unsigned c_STATE_W     = 2;
    localparam logic [1:0]  c_ST_UNLOCKED = 2'd0;
    localparam logic [1:0]  c_ST_ACQUIRE  = 2'd1;
    localparam logic [1:0]  c_ST_LOCKED   = 2'd2;
    localparam logic [1:0]  c_ST_HOLDOVER = 2'd3;

    // |val| for a width-bit two's complement value carried sign-extended in
    // 32 bits. The most negative input has no positive twin, so the result is
    // clamped to the largest positive value of that width.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] val,
                                            input int unsigned        width);
        logic [31:0] lim;
        logic [31:0] mag;
        lim = (32'd1 << (width - 1)) - 32'd1;
        if (val < 0) begin
            mag = unsigned'(-val);
        end else begin
            mag = unsigned'(val);
        end
        if (mag > lim) begin
            mag = lim;
        end
        return mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ref_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ref_edge_sync
//  Brief    : Two-flop synchroniser for the asynchronous reference clock,
//             followed by a registered rising-edge strobe. The strobe is high
//             for one clk cycle, three clk edges after the reference rises.
//  Revision : 1.0 - initial release
// ============================================================================
module ref_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_ref_clk,
    output logic o_sample
);

    logic r_meta;
    logic r_sync;
    logic r_sync_q;
    logic r_sample;

    // Synchronise the reference, delay it once more and register the rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_q <= 1'b0;
            r_sample <= 1'b0;
        end else begin
            r_meta   <= i_ref_clk;
            r_sync   <= r_meta;
            r_sync_q <= r_sync;
            r_sample <= r_sync & ~r_sync_q;
        end
    end

    assign o_sample = r_sample;

endmodule
`default_nettype wire

// File: rtl/adpll_lock_detect.sv
`default_nettype none
// ============================================================================
//  Module   : adpll_lock_detect
//  Brief    : Lock detector / error monitor for the ADPLL. Samples the signed
//             phase error once per reference rising edge, declares lock after
//             LOCK_COUNT consecutive in-threshold samples, rides through short
//             excursions in HOLDOVER, and drops lock on UNLOCK_COUNT bad
//             samples or on a reference-loss watchdog timeout.
//             Optional peak |error| register enabled by ADPLL_LOCK_PEAK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module adpll_lock_detect
    import adpll_pkg::*;
#(
    parameter int ERR_WIDTH    = 8,
    parameter int LOCK_THRESH  = 4,
    parameter int LOCK_COUNT   = 256,
    parameter int UNLOCK_COUNT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                 fpga_clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 ref_clk_i,
    input  logic [ERR_WIDTH-1:0] error_i,
    input  logic                 clear_peak_i,
    output logic                 locked_o,
    output logic [1:0]           state_o,
    output logic                 lock_lost_o,
    output logic [ERR_WIDTH-1:0] peak_err_o
);

    localparam int c_GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int c_BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam int c_WD_W   = $clog2(TIMEOUT + 1);

    localparam logic [c_GOOD_W-1:0] c_GOOD_MAX = c_GOOD_W'(LOCK_COUNT);
    localparam logic [c_BAD_W-1:0]  c_BAD_MAX  = c_BAD_W'(UNLOCK_COUNT);
    localparam logic [c_WD_W-1:0]   c_WD_MAX   = c_WD_W'(TIMEOUT);

    logic                  w_sample;
    logic signed [31:0]    w_err_ext;
    logic [31:0]           w_mag;
    logic                  w_in_thr;

    logic [c_STATE_W-1:0]  r_state;
    logic [c_STATE_W-1:0]  w_state_next;
    logic [c_GOOD_W-1:0]   r_good_cnt;
    logic [c_GOOD_W-1:0]   w_good_next;
    logic [c_GOOD_W-1:0]   w_good_inc;
    logic [c_BAD_W-1:0]    r_bad_cnt;
    logic [c_BAD_W-1:0]    w_bad_next;
    logic [c_BAD_W-1:0]    w_bad_inc;
    logic [c_WD_W-1:0]     r_wd_cnt;
    logic [c_WD_W-1:0]     w_wd_next;
    logic [c_WD_W-1:0]     w_wd_inc;
    logic                  w_timeout;

    logic                  r_locked;
    logic                  w_locked_next;
    logic                  r_lock_lost;
    logic                  w_lock_lost_next;

    ref_edge_sync u_ref_edge_sync (
        .clk       (fpga_clk_i),
        .rst       (reset_i),
        .i_ref_clk (ref_clk_i),
        .o_sample  (w_sample)
    );

    // Magnitude of the phase error; -2^(N-1) saturates to 2^(N-1)-1.
    assign w_err_ext = {{(32 - ERR_WIDTH){error_i[ERR_WIDTH-1]}}, error_i};
    assign w_mag     = sat_abs(w_err_ext, ERR_WIDTH);
    assign w_in_thr  = (w_mag <= 32'(LOCK_THRESH));

    // Counter increments; watchdog saturates so it never wraps back to zero.
    assign w_good_inc = r_good_cnt + c_GOOD_W'(1);
    assign w_bad_inc  = r_bad_cnt + c_BAD_W'(1);
    assign w_wd_inc   = (r_wd_cnt == c_WD_MAX) ? r_wd_cnt : r_wd_cnt + c_WD_W'(1);

    // A sample always restarts the watchdog, so it can only expire on a
    // sample-free cycle; once saturated it keeps forcing UNLOCKED harmlessly.
    assign w_timeout = ~w_sample & (w_wd_inc == c_WD_MAX);

    // State register with its counters and the registered outputs.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= c_ST_UNLOCKED;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_wd_cnt    <= '0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_good_cnt  <= w_good_next;
            r_bad_cnt   <= w_bad_next;
            r_wd_cnt    <= w_wd_next;
            r_locked    <= w_locked_next;
            r_lock_lost <= w_lock_lost_next;
        end
    end

    // Next-state and counter update: disable, then watchdog, then sample.
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        w_bad_next   = r_bad_cnt;
        w_wd_next    = r_wd_cnt;
        if (!enable_i) begin
            w_state_next = c_ST_UNLOCKED;
            w_good_next  = '0;
            w_bad_next   = '0;
            w_wd_next    = '0;
        end else if (w_timeout) begin
            w_state_next = c_ST_UNLOCKED;
            w_good_next  = '0;
            w_bad_next   = '0;
            w_wd_next    = w_wd_inc;
        end else if (w_sample) begin
            w_wd_next = '0;
            case (r_state)
                c_ST_UNLOCKED: begin
                    if (w_in_thr) begin
                        w_state_next = c_ST_ACQUIRE;
                        w_good_next  = c_GOOD_W'(1);
                    end
                end
                c_ST_ACQUIRE: begin
                    if (w_in_thr) begin
                        w_good_next = w_good_inc;
                        if (w_good_inc == c_GOOD_MAX) begin
                            w_state_next = c_ST_LOCKED;
                        end
                    end else begin
                        w_state_next = c_ST_UNLOCKED;
                        w_good_next  = '0;
                    end
                end
                c_ST_LOCKED: begin
                    if (!w_in_thr) begin
                        w_state_next = c_ST_HOLDOVER;
                        w_bad_next   = c_BAD_W'(1);
                    end
                end
                c_ST_HOLDOVER: begin
                    if (w_in_thr) begin
                        w_state_next = c_ST_LOCKED;
                        w_bad_next   = '0;
                    end else if (w_bad_inc == c_BAD_MAX) begin
                        w_state_next = c_ST_UNLOCKED;
                        w_good_next  = '0;
                        w_bad_next   = '0;
                    end else begin
                        w_bad_next = w_bad_inc;
                    end
                end
                default: begin
                    w_state_next = c_ST_UNLOCKED;
                    w_good_next  = '0;
                    w_bad_next   = '0;
                end
            endcase
        end else begin
            w_wd_next = w_wd_inc;
        end
    end

    // Output decode; a deliberate disable never reports a loss of lock.
    always_comb begin
        w_locked_next    = (w_state_next == c_ST_LOCKED) ||
                           (w_state_next == c_ST_HOLDOVER);
        w_lock_lost_next = enable_i &&
                           ((r_state == c_ST_LOCKED) || (r_state == c_ST_HOLDOVER)) &&
                           (w_state_next == c_ST_UNLOCKED);
    end

    assign locked_o    = r_locked;
    assign state_o     = r_state;
    assign lock_lost_o = r_lock_lost;

`ifdef ADPLL_LOCK_PEAK_EN
    logic [ERR_WIDTH-1:0] r_peak;

    // Peak |error| tracker; a clear wins over a coincident sample.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_peak <= '0;
        end else if (enable_i) begin
            if (clear_peak_i) begin
                r_peak <= '0;
            end else if (w_sample && (w_mag > 32'(r_peak))) begin
                r_peak <= w_mag[ERR_WIDTH-1:0];
            end
        end
    end

    assign peak_err_o = r_peak;
`else
    logic w_unused_clear_peak;

    assign w_unused_clear_peak = clear_peak_i;
    assign peak_err_o          = '0;
`endif

endmodule
`default_nettype wire

// File: doc/adpll_lock_detect.md
# adpll_lock_detect

Lock detector and error monitor sitting directly downstream of the ADPLL, consuming its signed phase-error output and the same reference clock. Samples the error once per reference rising edge and declares lock after a run of in-threshold samples. Provides hysteresis against transient excursions and tracks peak error magnitude for the seven-segment display path. Runs entirely in the 258 MHz `fpga_clk_i` domain.

## Interface
Parameters:
- `ERR_WIDTH`, 8: width of signed error input.
- `LOCK_THRESH`, 4: max |error| counted as in-threshold (inclusive).
- `LOCK_COUNT`, 256: consecutive in-threshold samples needed to declare lock.
- `UNLOCK_COUNT`, 4: consecutive out-of-threshold samples in HOLDOVER that drop lock.
- `TIMEOUT`, 255: `fpga_clk_i` cycles without a reference edge before forced loss.

Ports:
- `fpga_clk_i`  in  1  system clock, 258 MHz.
- `reset_i`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  detector enable; low forces UNLOCKED.
- `ref_clk_i`  in  1  reference clock, asynchronous; synchronised internally.
- `error_i`  in  ERR_WIDTH  signed phase error from ADPLL, synchronous to `fpga_clk_i`.
- `clear_peak_i`  in  1  single-cycle clear of peak register.
- `locked_o`  out  1  high in LOCKED or HOLDOVER.
- `state_o`  out  2  current state encoding.
- `lock_lost_o`  out  1  one-cycle pulse on LOCKED/HOLDOVER → UNLOCKED.
- `peak_err_o`  out  ERR_WIDTH  unsigned peak |error| since last clear.

## Operation
- Reference path: two-flop synchroniser, then edge-detect flop; `sample` strobe is high for one cycle per ref rising edge.
- Magnitude: |error_i|; most-negative value (-128) saturates to 127.
- `in_thr` = magnitude ≤ LOCK_THRESH, evaluated only on `sample`.
- States: UNLOCKED=0, ACQUIRE=1, LOCKED=2, HOLDOVER=3.
- UNLOCKED: sample & in_thr → ACQUIRE, good_cnt=1.
- ACQUIRE: sample & in_thr → good_cnt+1; when the incremented count equals LOCK_COUNT → LOCKED. sample & !in_thr → UNLOCKED, good_cnt=0.
- LOCKED: sample & !in_thr → HOLDOVER, bad_cnt=1.
- HOLDOVER: sample & in_thr → LOCKED, bad_cnt=0. sample & !in_thr → bad_cnt+1; on reaching UNLOCK_COUNT → UNLOCKED, pulse `lock_lost_o`.
- Watchdog: counter clears on every `sample`, otherwise increments (saturating); reaching TIMEOUT forces UNLOCKED from any state, clears counters, pulses `lock_lost_o` if leaving LOCKED/HOLDOVER.
- `enable_i` low: state UNLOCKED, good/bad/watchdog counters held at 0, no `lock_lost_o` pulse, peak held. Re-enable starts from UNLOCKED.
- Priority per cycle: reset > !enable_i > watchdog > sample transitions.
- Counter widths: $clog2(LOCK_COUNT+1), $clog2(UNLOCK_COUNT+1), $clog2(TIMEOUT+1); never wrap.

## Timing
- Reset values: `state_o`=0, `locked_o`=0, `lock_lost_o`=0, `peak_err_o`=0, synchroniser flops=0, all counters 0.
- Ref rising edge to `sample`: 3 `fpga_clk_i` cycles (2 sync + 1 edge).
- `error_i` captured on the `sample` cycle; state, `locked_o`, `lock_lost_o` update on the following edge (1-cycle latency from `sample`).
- All outputs are registered; `lock_lost_o` is exactly one cycle wide.
- Reset asserted mid-operation: all state returns to reset values immediately; no `lock_lost_o` pulse.

## Configuration
- `ADPLL_LOCK_PEAK_EN` defined: peak register present; on `sample` with enable high, peak = max(peak, magnitude); `clear_peak_i` sets peak to 0 and wins over a simultaneous sample (that sample is discarded for peak only).
- Undefined: no peak logic; `peak_err_o` tied to 0; `clear_peak_i` ignored.

## Structure
- Shared package `adpll_pkg`: state encoding constants (UNLOCKED/ACQUIRE/LOCKED/HOLDOVER), saturating-abs function for ERR_WIDTH signed values.
- One sub-module `ref_edge_sync`: two-flop synchroniser plus rising-edge strobe, async active-high reset.

## Test plan
- Reset, then 256 ref edges with `error_i`=3 → `locked_o` rises 1 cycle after the 256th `sample`; `state_o`=2.
- Locked, 3 samples with `error_i`=-9 then one with 2 → HOLDOVER then LOCKED; `lock_lost_o` never pulses.
- Locked, 4 samples with `error_i`=20 → UNLOCKED after the 4th, `lock_lost_o` high exactly 1 cycle.
- Locked, stop `ref_clk_i` → forced UNLOCKED 255 cycles after last `sample`, one `lock_lost_o` pulse.
- `error_i`=-128 sampled with `ADPLL_LOCK_PEAK_EN` → `peak_err_o`=127; `clear_peak_i` on next sample cycle → 0.
- ACQUIRE at good_cnt=100, deassert `enable_i` → UNLOCKED next cycle, no pulse; re-enable requires full 256 samples.
